rr_arb4_mux_stage: RTL

- Upstream feeder stage for the 4:1 datapath mux: arbitrates four valid/ready source streams round-robin and drives the 2-bit select.
- Registers the selected WIDTH-bit word into a single-entry output buffer with valid/ready handshake.
- Sits between four producers (e.g. ALU result, operand registers) and a single downstream consumer.
- Data selection reuses the existing MUX4to1 block internally. Grant/pointer logic is new.

---
 rtl/arb4_pkg.sv | 21 ++
 rtl/MUX4to1.sv | 26 ++
 rtl/rr_grant4.sv | 36 +++
 rtl/rr_arb4_mux_stage.sv | 110 +++++++++++
 4 files changed

// File: rtl/arb4_pkg.sv
// Shared types for the 4-source round-robin feeder in front of the 4:1 mux.
//   sel_t    : 2-bit source index / mux select
//   NUM_SRC  : number of arbitrated sources
//   state_t  : output buffer occupancy (EMPTY / FULL)
//   next_ptr : round-robin successor of a source index (3 wraps to 0)
package arb4_pkg;

  localparam int NUM_SRC = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic sel_t next_ptr(input sel_t idx);
    next_ptr = idx + sel_t'(1);
  endfunction

endpackage

// File: rtl/MUX4to1.sv
// Existing 4:1 datapath mux, reused unchanged by the feeder stage.
// Ports:
//   Sel    : 2-bit select
//   D0..D3 : WIDTH-bit data inputs
//   Y      : selected word (combinational)
module MUX4to1 #(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       Sel,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [WIDTH-1:0] D3,
  output logic [WIDTH-1:0] Y
);

  always_comb begin
    unique case (Sel)
      2'd0:    Y = D0;
      2'd1:    Y = D1;
      2'd2:    Y = D2;
      default: Y = D3;
    endcase
  end

endmodule

// File: rtl/rr_grant4.sv
// Combinational round-robin grant for four requesters.
// Searches ptr, ptr+1, ptr+2, ptr+3 (mod 4) and grants the first requester
// found. With en low nothing is granted.
// Ports:
//   req     : per-source request
//   ptr     : highest-priority index for this cycle
//   en      : grant enable (buffer able to accept a beat)
//   gnt_vld : a grant exists
//   gnt_idx : granted index (equals ptr when no grant)
module rr_grant4
  import arb4_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  sel_t               ptr,
  input  logic               en,
  output logic               gnt_vld,
  output sel_t               gnt_idx
);

  sel_t cand;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr;
    cand    = ptr;
    for (int k = 0; k < NUM_SRC; k++) begin
      // 2-bit addition wraps naturally, giving the modulo-4 search order.
      cand = ptr + sel_t'(k);
      if (en && !gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arb4_mux_stage.sv
// Feeder stage for the 4:1 datapath mux. Arbitrates four valid/ready
// sources round-robin, drives the mux select and registers the selected
// word into a single-entry output buffer with a valid/ready handshake.
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : per-source valid (bit i belongs to Di)
//   in_ready  : per-source ready, one-hot or zero
//   D0..D3    : source data words
//   sel       : mux select (granted index, else ptr)
//   out_valid : output buffer holds a beat
//   out_ready : consumer accepts the beat
//   out_data  : registered selected word
//   out_src   : index of the source that produced out_data
//
// State  | meaning
// -------+-----------------------------------------------
// EMPTY  | buffer holds no beat, out_valid = 0
// FULL   | buffer holds a beat, out_valid = 1
module rr_arb4_mux_stage
  import arb4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_SRC-1:0]  in_valid,
  output logic [NUM_SRC-1:0]  in_ready,
  input  logic [WIDTH-1:0]    D0,
  input  logic [WIDTH-1:0]    D1,
  input  logic [WIDTH-1:0]    D2,
  input  logic [WIDTH-1:0]    D3,
  output logic [1:0]          sel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [1:0]          out_src
);

  state_t           state;
  sel_t             ptr;
  logic             can_load;
  logic             grant_en;
  logic             gnt_vld;
  sel_t             gnt_idx;
  logic [WIDTH-1:0] mux_y;

  assign out_valid = (state == FULL);

  // Buffer can take a beat when empty or when its beat leaves this cycle.
  // The grant depends only on in_valid, state, out_ready and ptr, so
  // in_ready never feeds back into itself.
  assign can_load = (state == EMPTY) || out_ready;

  // Reset is asynchronous: keep every ready low while it is held so no
  // source sees a handshake that the buffer will never capture.
  assign grant_en = can_load && rst_n;

  rr_grant4 u_grant (
    .req     (in_valid),
    .ptr     (ptr),
    .en      (grant_en),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    in_ready = '0;
    if (gnt_vld) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  assign sel = gnt_vld ? gnt_idx : ptr;

  MUX4to1 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .Sel (sel),
    .D0  (D0),
    .D1  (D1),
    .D2  (D2),
    .D3  (D3),
    .Y   (mux_y)
  );

  // A grant is only ever issued to a requester with valid high, so a grant
  // is the transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      ptr      <= '0;
      out_data <= '0;
      out_src  <= '0;
    end else begin
      unique case (state)
        EMPTY: if (gnt_vld) state <= FULL;
        FULL:  if (out_ready && !gnt_vld) state <= EMPTY;
        default: state <= EMPTY;
      endcase
      if (gnt_vld) begin
        out_data <= mux_y;
        out_src  <= gnt_idx;
        ptr      <= next_ptr(gnt_idx);
      end
    end
  end

endmodule
